sprite_plotter: RTL and testbench

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

---
 rtl/mario_pkg.sv | 27 ++
 rtl/sprite_addr_gen.sv | 50 +++++
 rtl/sprite_plotter.sv | 167 ++++++++++++++++
 tb/tb_sprite_plotter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared constants and types for the sprite plotting path: screen geometry,
// the 3-bit VGA palette and the plotter state encoding.
package mario_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned SPRITE_W = 4;
   localparam int unsigned SPRITE_H = 4;

   // 3-bit RGB palette as understood by the VGA adapter
   localparam logic [2:0] COL_BLACK   = 3'd0;
   localparam logic [2:0] COL_BLUE    = 3'd1;
   localparam logic [2:0] COL_GREEN   = 3'd2;
   localparam logic [2:0] COL_CYAN    = 3'd3;
   localparam logic [2:0] COL_RED     = 3'd4;
   localparam logic [2:0] COL_MAGENTA = 3'd5;
   localparam logic [2:0] COL_YELLOW  = 3'd6;
   localparam logic [2:0] COL_WHITE   = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } plot_state_e;

endpackage

// File: rtl/sprite_addr_gen.sv
// Pixel walker for one 4x4 sprite square. cnt_q is the index of the pixel
// currently held on the plotter's output registers; the coordinate outputs
// describe the pixel that will be registered at the next edge, so the
// plotter can keep every VGA output purely registered.
module sprite_addr_gen
   import mario_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       load_i,     // next pixel is index 0 of a new phase
   input  logic       step_i,     // next pixel is cnt_q + 1
   input  logic [7:0] base_x_i,   // top-left of the square for the next pixel
   input  logic [6:0] base_y_i,
   output logic       last_o,     // pixel 15 is on the outputs now
   output logic [7:0] pix_x_o,
   output logic [6:0] pix_y_o,
   output logic       pix_on_o    // next pixel lies on screen
);

   localparam logic [8:0] X_LIM = 9'(SCREEN_W);
   localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

   logic [3:0] cnt_q, cnt_d;
   logic [3:0] idx;
   logic [8:0] sum_x;
   logic [7:0] sum_y;

   // Next pixel index, offset addition with a carry bit, and clip test
   always_comb begin
      // NOTE: every signal assigned here gets a value on every path first, otherwise a latch is inferred.
      idx   = load_i ? 4'd0 : cnt_q + 4'd1;
      cnt_d = (load_i || step_i) ? idx : cnt_q;
      // row-major walk: dx = idx[1:0] runs fastest, dy = idx[3:2]
      sum_x = {1'b0, base_x_i} + {7'd0, idx[1:0]};
      sum_y = {1'b0, base_y_i} + {6'd0, idx[3:2]};
      pix_on_o = (sum_x < X_LIM) && (sum_y < Y_LIM);
      pix_x_o  = sum_x[7:0];
      pix_y_o  = sum_y[6:0];
   end

   // Pixel counter register
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!resetn) cnt_q <= 4'd0;
      else         cnt_q <= cnt_d;
   end

   assign last_o = (cnt_q == 4'd15);

endmodule

// File: rtl/sprite_plotter.sv
// Redraws a 4x4 sprite on a 160x120 VGA frame buffer: optionally erases the
// square at the previous position with the background colour, then draws the
// square at the new position, one pixel per clock. All outputs are registered.
module sprite_plotter
   import mario_pkg::*;
#(
   parameter logic [2:0] BG_COLOUR = 3'd0,
   parameter bit         ERASE_EN  = 1'b1
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] new_x,
   input  logic [6:0] new_y,
   input  logic [2:0] new_colour,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       frame_done
);

   plot_state_e state_q;
   logic        ready_q;
   logic        have_old_q;
   logic [7:0]  old_x_q, pos_x_q;
   logic [6:0]  old_y_q, pos_y_q;
   logic [2:0]  colour_q;
   logic [7:0]  vga_x_q;
   logic [6:0]  vga_y_q;
   logic [2:0]  vga_colour_q;
   logic        vga_plot_q;
   logic        frame_done_q;

   logic        accept;
   logic        erase_go;
   logic        gen_load, gen_step, gen_last, gen_on;
   logic [7:0]  gen_base_x, gen_x;
   logic [6:0]  gen_base_y, gen_y;

   // ready_q is only ever 1 in IDLE, so it doubles as the accept qualifier
   assign accept   = req_valid && ready_q;
   assign erase_go = ERASE_EN && have_old_q;

   // Select the square and counter action for the pixel registered next
   always_comb begin
      gen_load   = 1'b0;
      gen_step   = 1'b0;
      gen_base_x = pos_x_q;
      gen_base_y = pos_y_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               gen_load = 1'b1;
               // the request is latched on this same edge, so draw straight from the inputs
               gen_base_x = erase_go ? old_x_q : new_x;
               gen_base_y = erase_go ? old_y_q : new_y;
            end
         end
         ERASE: begin
            if (gen_last) begin
               gen_load = 1'b1;
            end else begin
               gen_step   = 1'b1;
               gen_base_x = old_x_q;
               gen_base_y = old_y_q;
            end
         end
         DRAW: begin
            gen_step = !gen_last;
         end
         default: ;
      endcase
   end

   sprite_addr_gen u_addr_gen (
      .clk      (clk),
      .resetn   (resetn),
      .load_i   (gen_load),
      .step_i   (gen_step),
      .base_x_i (gen_base_x),
      .base_y_i (gen_base_y),
      .last_o   (gen_last),
      .pix_x_o  (gen_x),
      .pix_y_o  (gen_y),
      .pix_on_o (gen_on)
   );

   // Redraw FSM with registered VGA outputs, handshake and position history
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         have_old_q   <= 1'b0;
         old_x_q      <= 8'd0;
         old_y_q      <= 7'd0;
         pos_x_q      <= 8'd0;
         pos_y_q      <= 7'd0;
         colour_q     <= 3'd0;
         vga_x_q      <= 8'd0;
         vga_y_q      <= 7'd0;
         vga_colour_q <= 3'd0;
         vga_plot_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  pos_x_q      <= new_x;
                  pos_y_q      <= new_y;
                  colour_q     <= new_colour;
                  ready_q      <= 1'b0;
                  state_q      <= erase_go ? ERASE : DRAW;
                  vga_x_q      <= gen_x;
                  vga_y_q      <= gen_y;
                  vga_colour_q <= erase_go ? BG_COLOUR : new_colour;
                  vga_plot_q   <= gen_on;
               end
            end
            ERASE: begin
               vga_x_q    <= gen_x;
               vga_y_q    <= gen_y;
               vga_plot_q <= gen_on;
               if (gen_last) begin
                  state_q      <= DRAW;
                  vga_colour_q <= colour_q;
               end else begin
                  vga_colour_q <= BG_COLOUR;
               end
            end
            DRAW: begin
               if (gen_last) begin
                  state_q      <= DONE;
                  vga_x_q      <= 8'd0;
                  vga_y_q      <= 7'd0;
                  vga_colour_q <= 3'd0;
                  vga_plot_q   <= 1'b0;
                  frame_done_q <= 1'b1;
                  old_x_q      <= pos_x_q;
                  old_y_q      <= pos_y_q;
                  have_old_q   <= 1'b1;
               end else begin
                  vga_x_q      <= gen_x;
                  vga_y_q      <= gen_y;
                  vga_colour_q <= colour_q;
                  vga_plot_q   <= gen_on;
               end
            end
            DONE: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: one instance with erase enabled, one
// with erase disabled, sharing stimulus through a select line.
module tb_sprite_plotter;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] new_x = 8'd0;
   logic [6:0] new_y = 7'd0;
   logic [2:0] new_colour = 3'd0;

   logic       v1, v2;
   logic       rdy1, rdy2, plot1, plot2, fd1, fd2;
   logic [7:0] x1, x2;
   logic [6:0] y1, y2;
   logic [2:0] c1, c2;

   logic       o_rdy, o_plot, o_fd;
   logic [7:0] o_x;
   logic [6:0] o_y;
   logic [2:0] o_c;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   assign v1 = req_valid & ~sel;
   assign v2 = req_valid & sel;

   sprite_plotter u_dut (
      .clk(clk), .resetn(resetn), .req_valid(v1), .req_ready(rdy1),
      .new_x(new_x), .new_y(new_y), .new_colour(new_colour),
      .vga_x(x1), .vga_y(y1), .vga_colour(c1), .vga_plot(plot1), .frame_done(fd1)
   );

   sprite_plotter #(.BG_COLOUR(3'd0), .ERASE_EN(1'b0)) u_dut_noerase (
      .clk(clk), .resetn(resetn), .req_valid(v2), .req_ready(rdy2),
      .new_x(new_x), .new_y(new_y), .new_colour(new_colour),
      .vga_x(x2), .vga_y(y2), .vga_colour(c2), .vga_plot(plot2), .frame_done(fd2)
   );

   assign o_rdy  = sel ? rdy2  : rdy1;
   assign o_plot = sel ? plot2 : plot1;
   assign o_fd   = sel ? fd2   : fd1;
   assign o_x    = sel ? x2    : x1;
   assign o_y    = sel ? y2    : y1;
   assign o_c    = sel ? c2    : c1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One redraw: offer at a negedge, accept at the following posedge (E0),
   // then check every cycle through frame_done and the return of req_ready.
   task automatic run_frame(input int nx, input int ny, input int nc,
                            input bit exp_erase, input int ox, input int oy,
                            input bit hold, input int abort_px, input int exp_strobes);
      int total;
      int draw_plots;
      int p, bx, by, ex, ey;
      bit er, on;
      total      = exp_erase ? 32 : 16;
      draw_plots = 0;
      @(negedge clk);
      new_x      = 8'(nx);
      new_y      = 7'(ny);
      new_colour = 3'(nc);
      req_valid  = 1'b1;
      check("ready_idle", o_rdy, 1);
      @(posedge clk);
      for (int k = 1; k <= total + 2; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (hold) begin
               // junk on the inputs must not be picked up mid-redraw
               new_x      = 8'd100;
               new_y      = 7'd50;
               new_colour = 3'd7;
            end else begin
               req_valid = 1'b0;
            end
         end
         if (k <= total) begin
            er = exp_erase && (k <= 16);
            p  = (k - 1) % 16;
            bx = er ? ox : nx;
            by = er ? oy : ny;
            ex = bx + (p % 4);
            ey = by + (p / 4);
            on = (ex < 160) && (ey < 120);
            check(er ? "erase_plot" : "draw_plot", o_plot, on);
            if (on) begin
               check(er ? "erase_x" : "draw_x", o_x, ex);
               check(er ? "erase_y" : "draw_y", o_y, ey);
               check(er ? "erase_colour" : "draw_colour", o_c, er ? 0 : nc);
               if (!er) draw_plots++;
            end
            check("ready_busy", o_rdy, 0);
            check("done_busy", o_fd, 0);
            if (!er && p == abort_px) begin
               resetn = 1'b0;
               #1;
               check("abort_plot", o_plot, 0);
               check("abort_x", o_x, 0);
               check("abort_ready", o_rdy, 1);
               @(negedge clk);
               check("abort_no_plot", o_plot, 0);
               resetn = 1'b1;
               return;
            end
         end else if (k == total + 1) begin
            check("frame_done", o_fd, 1);
            check("done_plot", o_plot, 0);
            check("done_x", o_x, 0);
            check("done_y", o_y, 0);
            check("done_colour", o_c, 0);
            check("done_ready", o_rdy, 0);
         end else begin
            if (hold) req_valid = 1'b0;
            check("ready_again", o_rdy, 1);
            check("done_pulse_end", o_fd, 0);
            check("idle_plot", o_plot, 0);
         end
      end
      check("draw_strobes", draw_plots, exp_strobes);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_plot", o_plot, 0);
      check("rst_x", o_x, 0);
      check("rst_y", o_y, 0);
      check("rst_colour", o_c, 0);
      check("rst_done", o_fd, 0);
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", o_rdy, 1);
      check("post_rst_plot", o_plot, 0);

      // erase-enabled instance
      run_frame(10, 20, 1, 1'b0, 0, 0, 1'b0, -1, 16);
      run_frame(11, 20, 2, 1'b1, 10, 20, 1'b0, -1, 16);
      run_frame(158, 118, 4, 1'b1, 11, 20, 1'b0, -1, 4);
      run_frame(20, 30, 5, 1'b1, 158, 118, 1'b1, -1, 16);
      run_frame(21, 30, 6, 1'b1, 20, 30, 1'b0, -1, 16);
      run_frame(21, 30, 6, 1'b1, 21, 30, 1'b0, -1, 16);
      run_frame(40, 40, 3, 1'b1, 21, 30, 1'b0, 7, 16);
      run_frame(50, 60, 2, 1'b0, 0, 0, 1'b0, -1, 16);

      // erase-disabled instance: second request still has no erase phase
      sel = 1'b1;
      run_frame(5, 5, 1, 1'b0, 0, 0, 1'b0, -1, 16);
      run_frame(6, 5, 2, 1'b0, 0, 0, 1'b0, -1, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
